// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: operating modes and the
// saturating-counter helpers used by the pattern history table.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_STATIC  = 2'd0,
    BP_BIMODAL = 2'd1,
    BP_GSHARE  = 2'd2
  } bp_mode_e;

  // Weakly not-taken: one below the taken threshold (0 for 1-bit counters).
  function automatic int unsigned cnt_init(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned sat_step(input int unsigned cnt,
                                           input logic        up,
                                           input int unsigned cnt_w);
    int unsigned max_v;
    max_v = (32'd1 << cnt_w) - 32'd1;
    if (up) begin
      return (cnt >= max_v) ? max_v : cnt + 32'd1;
    end
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: array of saturating counters with one
// combinational read port and one clocked saturating update port.
module bp_pht
  import bp_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_up_i
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] INIT = CNT_W'(cnt_init(CNT_W));

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];

  // No write-to-read bypass: a same-cycle lookup sees the pre-update value.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en_i) begin
      cnt_d[wr_idx_i] = CNT_W'(sat_step(32'(cnt_q[wr_idx_i]), wr_up_i, CNT_W));
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= INIT;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_prediction_unit.sv
// Dynamic branch predictor: ID-stage lookup, EX-stage training,
// mispredict flush generation and resolved-branch statistics.
module branch_prediction_unit
  import bp_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 4,
  parameter int MODE   = 1,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [PC_W-1:0]   id_pc,
  output logic              id_predict_taken,
  output logic [IDX_W-1:0]  id_index,
  input  logic              ex_valid,
  input  logic [IDX_W-1:0]  ex_index,
  input  logic              ex_predicted,
  input  logic              ex_taken,
  output logic              flush_id_ex,
  input  logic              stat_clear,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam bit IS_STATIC = (MODE == int'(BP_STATIC));
  localparam bit IS_GSHARE = (MODE == int'(BP_GSHARE));

  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [STAT_W-1:0] branches_q, branches_d;
  logic [STAT_W-1:0] mispredicts_q, mispredicts_d;
  logic [IDX_W-1:0]  lookup_idx;
  logic [CNT_W-1:0]  rd_cnt;
  logic              unused_pc;

  assign unused_pc = ^{id_pc[PC_W-1:IDX_W+2], id_pc[1:0]};

  always_comb begin
    lookup_idx = id_pc[IDX_W+1:2];
    if (IS_GSHARE) begin
      lookup_idx = lookup_idx ^ IDX_W'(ghr_q);
    end
  end

  assign id_index         = lookup_idx;
  assign id_predict_taken = IS_STATIC ? 1'b0 : rd_cnt[CNT_W-1];

  // ex_valid qualifies ex_index/ex_predicted/ex_taken for exactly one cycle;
  // there is no backpressure, every asserted cycle is one resolved branch.
  assign flush_id_ex = ex_valid & (ex_predicted != ex_taken);

  bp_pht #(
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) u_pht (
    .clk      (clk),
    .arst     (arst),
    .rd_idx_i (lookup_idx),
    .rd_cnt_o (rd_cnt),
    .wr_en_i  (ex_valid && !IS_STATIC),
    .wr_idx_i (ex_index),
    .wr_up_i  (ex_taken)
  );

  always_comb begin
    ghr_d = ghr_q;
    if (IS_GSHARE && ex_valid) begin
      ghr_d = HIST_W'({ghr_q, ex_taken});
    end
  end

  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (stat_clear) begin
      branches_d    = '0;
      mispredicts_d = '0;
    end else begin
      if (ex_valid && !(&branches_q)) begin
        branches_d = branches_q + STAT_W'(1);
      end
      if (flush_id_ex && !(&mispredicts_q)) begin
        mispredicts_d = mispredicts_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ghr_q         <= '0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      ghr_q         <= ghr_d;
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Bench: bimodal, gshare and static (2-bit stats) predictors driven in
// parallel and compared against a counter-array reference model.
module tb_branch_prediction_unit;

  localparam int NDUT = 3;
  localparam int CMAX = 3;

  logic        clk;
  logic        arst;
  logic [31:0] id_pc;
  logic        ex_valid;
  logic [3:0]  ex_index;
  logic        ex_predicted;
  logic        ex_taken;
  logic        stat_clear;

  logic        pred0, pred1, pred2;
  logic [3:0]  idx0, idx1, idx2;
  logic        flush0, flush1, flush2;
  logic [31:0] br0, br1, mp0, mp1;
  logic [1:0]  br2, mp2;

  int checks = 0;
  int passes = 0;

  int              m_pht [NDUT][16];
  int              m_ghr [NDUT];
  longint unsigned m_br  [NDUT];
  longint unsigned m_mp  [NDUT];

  branch_prediction_unit #(.MODE(1)) dut_bi (
    .clk(clk), .arst(arst), .id_pc(id_pc), .id_predict_taken(pred0), .id_index(idx0),
    .ex_valid(ex_valid), .ex_index(ex_index), .ex_predicted(ex_predicted), .ex_taken(ex_taken),
    .flush_id_ex(flush0), .stat_clear(stat_clear), .stat_branches(br0), .stat_mispredicts(mp0)
  );

  branch_prediction_unit #(.MODE(2)) dut_gs (
    .clk(clk), .arst(arst), .id_pc(id_pc), .id_predict_taken(pred1), .id_index(idx1),
    .ex_valid(ex_valid), .ex_index(ex_index), .ex_predicted(ex_predicted), .ex_taken(ex_taken),
    .flush_id_ex(flush1), .stat_clear(stat_clear), .stat_branches(br1), .stat_mispredicts(mp1)
  );

  branch_prediction_unit #(.MODE(0), .STAT_W(2)) dut_st (
    .clk(clk), .arst(arst), .id_pc(id_pc), .id_predict_taken(pred2), .id_index(idx2),
    .ex_valid(ex_valid), .ex_index(ex_index), .ex_predicted(ex_predicted), .ex_taken(ex_taken),
    .flush_id_ex(flush2), .stat_clear(stat_clear), .stat_branches(br2), .stat_mispredicts(mp2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int mode_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 0;
  endfunction

  function automatic longint unsigned stat_max(input int d);
    return (d == 2) ? 64'd3 : 64'hFFFF_FFFF;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 16; i++) m_pht[d][i] = 1;
      m_ghr[d] = 0;
      m_br[d]  = 0;
      m_mp[d]  = 0;
    end
  endfunction

  function automatic int exp_idx(input int d, input logic [31:0] pc);
    int base;
    base = int'((pc >> 2) % 16);
    if (mode_of(d) == 2) base = base ^ m_ghr[d];
    return base;
  endfunction

  function automatic logic exp_pred(input int d, input logic [31:0] pc);
    if (mode_of(d) == 0) return 1'b0;
    return m_pht[d][exp_idx(d, pc)] >= 2;
  endfunction

  function automatic void model_edge();
    logic mis;
    mis = ex_valid && (ex_predicted != ex_taken);
    for (int d = 0; d < NDUT; d++) begin
      if (ex_valid && mode_of(d) != 0) begin
        if (ex_taken) m_pht[d][ex_index] = (m_pht[d][ex_index] < CMAX) ? m_pht[d][ex_index] + 1 : CMAX;
        else          m_pht[d][ex_index] = (m_pht[d][ex_index] > 0) ? m_pht[d][ex_index] - 1 : 0;
      end
      if (ex_valid && mode_of(d) == 2) m_ghr[d] = (m_ghr[d] * 2 + int'(ex_taken)) % 16;
      if (stat_clear) begin
        m_br[d] = 0;
        m_mp[d] = 0;
      end else begin
        if (ex_valid && m_br[d] < stat_max(d)) m_br[d] = m_br[d] + 1;
        if (mis && m_mp[d] < stat_max(d))      m_mp[d] = m_mp[d] + 1;
      end
    end
  endfunction

  // Observable state of one DUT packed as {index, predict, flush, branches, mispredicts}.
  function automatic logic [69:0] obs_sig(input int d);
    case (d)
      0:       return {idx0, pred0, flush0, br0, mp0};
      1:       return {idx1, pred1, flush1, br1, mp1};
      default: return {idx2, pred2, flush2, 30'd0, br2, 30'd0, mp2};
    endcase
  endfunction

  function automatic logic [69:0] exp_sig(input int d);
    logic fl;
    fl = ex_valid && (ex_predicted != ex_taken);
    return {4'(exp_idx(d, id_pc)), exp_pred(d, id_pc), fl, 32'(m_br[d]), 32'(m_mp[d])};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] pc, input logic v, input logic [3:0] idx,
                       input logic p, input logic t, input logic c);
    @(negedge clk);
    id_pc = pc; ex_valid = v; ex_index = idx; ex_predicted = p; ex_taken = t; stat_clear = c;
    #1;
  endtask

  task automatic edge_update();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    ex_valid = 1'b0; stat_clear = 1'b0;
    arst = 1'b1;
    model_reset();
    #1 arst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    arst = 1'b0;
    #1;
    checks++; if (idx0 !== 4'h0) $display("FAIL reset_index got %h exp 0", idx0); else passes++;
    checks++; if (pred0 !== 1'b0) $display("FAIL reset_predict got %b exp 0", pred0); else passes++;
    checks++; if (flush0 !== 1'b0) $display("FAIL reset_flush got %b exp 0", flush0); else passes++;
    checks++; if (br0 !== 32'd0 || mp0 !== 32'd0) $display("FAIL reset_stats got %0d/%0d exp 0/0", br0, mp0); else passes++;
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (obs_sig(d) !== exp_sig(d)) $display("FAIL reset_sig dut%0d got %h exp %h", d, obs_sig(d), exp_sig(d)); else passes++;
    end
    edge_update();
  endtask

  task automatic test_train();
    for (int k = 0; k < 2; k++) begin
      drive(32'h40, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (flush0 !== 1'b1) $display("FAIL train_flush%0d got %b exp 1", k, flush0); else passes++;
      for (int d = 0; d < NDUT; d++) begin
        checks++; if (obs_sig(d) !== exp_sig(d)) $display("FAIL train_sig dut%0d got %h exp %h", d, obs_sig(d), exp_sig(d)); else passes++;
      end
      edge_update();
    end
    drive(32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (pred0 !== 1'b1) $display("FAIL train_predict got %b exp 1", pred0); else passes++;
    checks++; if (br0 !== 32'd2 || mp0 !== 32'd2) $display("FAIL train_stats got %0d/%0d exp 2/2", br0, mp0); else passes++;
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (obs_sig(d) !== exp_sig(d)) $display("FAIL train_after dut%0d got %h exp %h", d, obs_sig(d), exp_sig(d)); else passes++;
    end
  endtask

  task automatic test_saturation();
    drive(32'h40, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    checks++; if (flush0 !== 1'b0) $display("FAIL sat_flush got %b exp 0", flush0); else passes++;
    edge_update();
    drive(32'h40, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (flush0 !== 1'b1) $display("FAIL sat_nt_flush got %b exp 1", flush0); else passes++;
    edge_update();
    drive(32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (pred0 !== 1'b1) $display("FAIL sat_predict_10 got %b exp 1", pred0); else passes++;
    drive(32'h40, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    edge_update();
    drive(32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (pred0 !== 1'b0) $display("FAIL sat_predict_01 got %b exp 0", pred0); else passes++;
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (obs_sig(d) !== exp_sig(d)) $display("FAIL sat_sig dut%0d got %h exp %h", d, obs_sig(d), exp_sig(d)); else passes++;
    end
  endtask

  task automatic test_gshare();
    logic [2:0] outcomes;
    outcomes = 3'b110;
    do_reset();
    for (int k = 2; k >= 0; k--) begin
      drive(32'h100, 1'b1, 4'd5, 1'b0, outcomes[k], 1'b0);
      edge_update();
    end
    drive(32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (idx1 !== 4'h6) $display("FAIL gshare_index got %h exp 6", idx1); else passes++;
    checks++; if (idx0 !== 4'h0) $display("FAIL bimodal_index got %h exp 0", idx0); else passes++;
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (obs_sig(d) !== exp_sig(d)) $display("FAIL gshare_sig dut%0d got %h exp %h", d, obs_sig(d), exp_sig(d)); else passes++;
    end
  endtask

  task automatic test_hazard();
    do_reset();
    drive(32'h4C, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    checks++; if (idx0 !== 4'h3) $display("FAIL hazard_index got %h exp 3", idx0); else passes++;
    checks++; if (pred0 !== 1'b0) $display("FAIL hazard_same_cycle got %b exp 0", pred0); else passes++;
    edge_update();
    drive(32'h4C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (pred0 !== 1'b1) $display("FAIL hazard_next_cycle got %b exp 1", pred0); else passes++;
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (obs_sig(d) !== exp_sig(d)) $display("FAIL hazard_sig dut%0d got %h exp %h", d, obs_sig(d), exp_sig(d)); else passes++;
    end
  endtask

  task automatic test_stat_sat();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive($urandom, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
      checks++; if (pred2 !== 1'b0) $display("FAIL static_predict%0d got %b exp 0", k, pred2); else passes++;
      edge_update();
    end
    drive(32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (mp2 !== 2'd3 || br2 !== 2'd3) $display("FAIL stat_saturate got %0d/%0d exp 3/3", br2, mp2); else passes++;
    checks++; if (mp0 !== 32'd5) $display("FAIL stat_wide got %0d exp 5", mp0); else passes++;
    drive(32'h40, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    edge_update();
    drive(32'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (mp2 !== 2'd0 || br2 !== 2'd0) $display("FAIL stat_clear got %0d/%0d exp 0/0", br2, mp2); else passes++;
    checks++; if (br0 !== 32'd0) $display("FAIL stat_clear_wide got %0d exp 0", br0); else passes++;
    for (int k = 0; k < 3; k++) begin
      drive(32'h40, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      edge_update();
    end
    @(negedge clk);
    ex_valid = 1'b0; id_pc = 32'h40;
    #2 arst = 1'b1;
    model_reset();
    #1;
    checks++; if (pred0 !== 1'b0) $display("FAIL arst_predict got %b exp 0", pred0); else passes++;
    checks++; if (br0 !== 32'd0 || mp2 !== 2'd0) $display("FAIL arst_stats got %0d/%0d exp 0/0", br0, mp2); else passes++;
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (obs_sig(d) !== exp_sig(d)) $display("FAIL arst_sig dut%0d got %h exp %h", d, obs_sig(d), exp_sig(d)); else passes++;
    end
    #1 arst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      for (int d = 0; d < NDUT; d++) begin
        checks++; if (obs_sig(d) !== exp_sig(d)) $display("FAIL random_sig cyc%0d dut%0d got %h exp %h", k, d, obs_sig(d), exp_sig(d)); else passes++;
      end
      edge_update();
    end
  endtask

  initial begin
    arst = 1'b1; id_pc = '0; ex_valid = 1'b0; ex_index = '0;
    ex_predicted = 1'b0; ex_taken = 1'b0; stat_clear = 1'b0;
    model_reset();
    test_reset();
    test_train();
    test_saturation();
    test_gshare();
    test_hazard();
    test_stat_sat();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
